sprite_step_controller: RTL and testbench

//  Consumes the toggling reduced_clock from the game rate divider and converts each toggle into one step of a maze

---
 rtl/sprite_step_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_sprite_step_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_step_controller.sv
// Turns reduced_clock toggles into maze steps for one sprite.
// Each step tries the requested direction, then falls back to the current
// direction. The maze wall ROM answers one cycle after each probe. A step
// that commits asks the plotter to erase the old cell and then draw the new
// one.
// Ports:
//   clock_50, reset          clock, synchronous active-high reset
//   en, reduced_clock        tick enable and the toggling tick source
//   dir_req, dir_req_valid   direction request strobe
//   probe_x/y, probe_wall    maze wall lookup (wall result is 1-cycle latency)
//   plot_req/ack, plot_x/y,  plotter handshake; erase=1 draws background
//   plot_erase
//   pos_x/y, cur_dir         sprite position and travelled direction
//   moved, tick_overrun      single-cycle status pulses
module sprite_step_controller #(
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned MAX_X   = 159,
    parameter int unsigned MAX_Y   = 119,
    parameter int unsigned START_X = 80,
    parameter int unsigned START_Y = 60,
    parameter logic [1:0]  START_D = 2'd2
) (
    input  logic           clock_50,
    input  logic           reset,
    input  logic           en,
    input  logic           reduced_clock,
    input  logic [1:0]     dir_req,
    input  logic           dir_req_valid,
    output logic [X_W-1:0] probe_x,
    output logic [Y_W-1:0] probe_y,
    input  logic           probe_wall,
    output logic           plot_req,
    input  logic           plot_ack,
    output logic [X_W-1:0] plot_x,
    output logic [Y_W-1:0] plot_y,
    output logic           plot_erase,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     cur_dir,
    output logic           moved,
    output logic           tick_overrun
);

    typedef enum logic [2:0] {
        IDLE, PROBE_P, CHK_P, PROBE_C, CHK_C, ERASE, DRAW
    } state_e;

    state_e         state_q, state_d;
    logic           rc_q, rc_d;
    logic           tick_pending_q, tick_pending_d;
    logic [1:0]     pending_dir_q, pending_dir_d;
    logic [1:0]     cur_dir_q, cur_dir_d;
    logic [1:0]     try_dir_q, try_dir_d;
    logic [X_W-1:0] pos_x_q, pos_x_d, tgt_x_q, tgt_x_d, probe_x_q, probe_x_d, plot_x_q, plot_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d, tgt_y_q, tgt_y_d, probe_y_q, probe_y_d, plot_y_q, plot_y_d;
    logic           plot_req_q, plot_req_d;
    logic           plot_erase_q, plot_erase_d;
    logic           moved_q, moved_d;
    logic           tick_overrun_q, tick_overrun_d;

    logic           tick_c;
    logic           tp_blk, tc_blk;
    logic [X_W-1:0] tp_x, tc_x;
    logic [Y_W-1:0] tp_y, tc_y;

    // Neighbour cell in direction d; MSB flags a vertical edge (blocked without a lookup).
    function automatic logic [X_W+Y_W:0] calc_target(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y,
                                                     input logic [1:0]     d);
        logic [X_W-1:0] nx;
        logic [Y_W-1:0] ny;
        logic           blk;
        nx  = x;
        ny  = y;
        blk = 1'b0;
        case (d)
            2'd0:    if (y == '0) blk = 1'b1; else ny = y - Y_W'(1);
            2'd1:    if (y == Y_W'(MAX_Y)) blk = 1'b1; else ny = y + Y_W'(1);
            2'd2:    nx = (x == '0) ? X_W'(MAX_X) : x - X_W'(1);
            default: nx = (x == X_W'(MAX_X)) ? '0 : x + X_W'(1);
        endcase
        return {blk, nx, ny};
    endfunction

    // Candidate targets for the requested and the current direction.
    always_comb begin
        {tp_blk, tp_x, tp_y} = calc_target(pos_x_q, pos_y_q, pending_dir_q);
        {tc_blk, tc_x, tc_y} = calc_target(pos_x_q, pos_y_q, cur_dir_q);
    end

    assign tick_c = reduced_clock ^ rc_q;

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        rc_d           = reduced_clock;
        tick_pending_d = tick_pending_q;
        pending_dir_d  = pending_dir_q;
        cur_dir_d      = cur_dir_q;
        try_dir_d      = try_dir_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        tgt_x_d        = tgt_x_q;
        tgt_y_d        = tgt_y_q;
        probe_x_d      = probe_x_q;
        probe_y_d      = probe_y_q;
        plot_req_d     = plot_req_q;
        plot_x_d       = plot_x_q;
        plot_y_d       = plot_y_q;
        plot_erase_d   = plot_erase_q;
        moved_d        = 1'b0;
        tick_overrun_d = 1'b0;

        if (dir_req_valid) pending_dir_d = dir_req;

        if (tick_c && en && tick_pending_q && (state_q != IDLE)) tick_overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tick_pending_q) begin
                    tick_pending_d = 1'b0;
                    // Direction under test is frozen so a mid-step request waits for the next tick.
                    try_dir_d      = pending_dir_q;
                    if (!tp_blk) begin
                        probe_x_d = tp_x;
                        probe_y_d = tp_y;
                        tgt_x_d   = tp_x;
                        tgt_y_d   = tp_y;
                        state_d   = PROBE_P;
                    end else if (!tc_blk) begin
                        probe_x_d = tc_x;
                        probe_y_d = tc_y;
                        tgt_x_d   = tc_x;
                        tgt_y_d   = tc_y;
                        state_d   = PROBE_C;
                    end
                end
            end
            PROBE_P: state_d = CHK_P;
            CHK_P: begin
                if (!probe_wall) begin
                    cur_dir_d    = try_dir_q;
                    plot_req_d   = 1'b1;
                    plot_x_d     = pos_x_q;
                    plot_y_d     = pos_y_q;
                    plot_erase_d = 1'b1;
                    state_d      = ERASE;
                end else if (!tc_blk) begin
                    probe_x_d = tc_x;
                    probe_y_d = tc_y;
                    tgt_x_d   = tc_x;
                    tgt_y_d   = tc_y;
                    state_d   = PROBE_C;
                end else begin
                    state_d = IDLE;
                end
            end
            PROBE_C: state_d = CHK_C;
            CHK_C: begin
                if (!probe_wall) begin
                    plot_req_d   = 1'b1;
                    plot_x_d     = pos_x_q;
                    plot_y_d     = pos_y_q;
                    plot_erase_d = 1'b1;
                    state_d      = ERASE;
                end else begin
                    state_d = IDLE;
                end
            end
            ERASE: begin
                if (plot_req_q && plot_ack) begin
                    plot_req_d   = 1'b0;
                    pos_x_d      = tgt_x_q;
                    pos_y_d      = tgt_y_q;
                    moved_d      = 1'b1;
                    plot_x_d     = tgt_x_q;
                    plot_y_d     = tgt_y_q;
                    plot_erase_d = 1'b0;
                    state_d      = DRAW;
                end
            end
            DRAW: begin
                // Request drops for one cycle after the erase ack, then re-asserts for the draw.
                if (!plot_req_q) begin
                    plot_req_d = 1'b1;
                end else if (plot_ack) begin
                    plot_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set after the IDLE clear so a same-cycle tick re-arms the flag.
        if (tick_c && en) tick_pending_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q        <= IDLE;
            rc_q           <= 1'b0;
            tick_pending_q <= 1'b0;
            pending_dir_q  <= START_D;
            cur_dir_q      <= START_D;
            try_dir_q      <= START_D;
            pos_x_q        <= X_W'(START_X);
            pos_y_q        <= Y_W'(START_Y);
            tgt_x_q        <= X_W'(START_X);
            tgt_y_q        <= Y_W'(START_Y);
            probe_x_q      <= X_W'(START_X);
            probe_y_q      <= Y_W'(START_Y);
            plot_req_q     <= 1'b0;
            plot_x_q       <= X_W'(START_X);
            plot_y_q       <= Y_W'(START_Y);
            plot_erase_q   <= 1'b0;
            moved_q        <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rc_q           <= rc_d;
            tick_pending_q <= tick_pending_d;
            pending_dir_q  <= pending_dir_d;
            cur_dir_q      <= cur_dir_d;
            try_dir_q      <= try_dir_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            tgt_x_q        <= tgt_x_d;
            tgt_y_q        <= tgt_y_d;
            probe_x_q      <= probe_x_d;
            probe_y_q      <= probe_y_d;
            plot_req_q     <= plot_req_d;
            plot_x_q       <= plot_x_d;
            plot_y_q       <= plot_y_d;
            plot_erase_q   <= plot_erase_d;
            moved_q        <= moved_d;
            tick_overrun_q <= tick_overrun_d;
        end
    end

    assign probe_x      = probe_x_q;
    assign probe_y      = probe_y_q;
    assign plot_req     = plot_req_q;
    assign plot_x       = plot_x_q;
    assign plot_y       = plot_y_q;
    assign plot_erase   = plot_erase_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign cur_dir      = cur_dir_q;
    assign moved        = moved_q;
    assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_sprite_step_controller.sv
// Self-checking bench for sprite_step_controller: maze ROM and plotter models,
// plus a step-level reference model that predicts plots and moves.
module tb_sprite_step_controller;

    localparam int MAX_X = 159;
    localparam int MAX_Y = 119;

    logic       clock_50, reset, en, reduced_clock, dir_req_valid, probe_wall, plot_ack;
    logic [1:0] dir_req;
    logic [7:0] probe_x, plot_x, pos_x;
    logic [6:0] probe_y, plot_y, pos_y;
    logic       plot_req, plot_erase, moved, tick_overrun;
    logic [1:0] cur_dir;

    sprite_step_controller dut (
        .clock_50(clock_50), .reset(reset), .en(en), .reduced_clock(reduced_clock),
        .dir_req(dir_req), .dir_req_valid(dir_req_valid),
        .probe_x(probe_x), .probe_y(probe_y), .probe_wall(probe_wall),
        .plot_req(plot_req), .plot_ack(plot_ack), .plot_x(plot_x), .plot_y(plot_y),
        .plot_erase(plot_erase), .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir),
        .moved(moved), .tick_overrun(tick_overrun)
    );

    typedef struct {int x; int y; int erase;} plot_t;
    typedef struct {int x; int y; int d;} mv_t;

    bit    wall_mem [0:MAX_X][0:MAX_Y];
    plot_t exp_plot[$];
    mv_t   exp_mv[$];
    int    probe_log[$];
    int    total = 0, bad = 0;
    int    m_x, m_y, m_cur, m_pend;
    int    cur_x, cur_y, moves_seen, req_cycles, seen_overrun, last_probe;
    int    ack_max = 0;
    bit    ack_hold = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void tgt(input int x, input int y, input int d,
                                output int tx, output int ty, output bit blk);
        tx = x; ty = y; blk = 0;
        case (d)
            0: if (y == 0) blk = 1; else ty = y - 1;
            1: if (y == MAX_Y) blk = 1; else ty = y + 1;
            2: tx = (x == 0) ? MAX_X : x - 1;
            default: tx = (x == MAX_X) ? 0 : x + 1;
        endcase
        if (!blk) blk = wall_mem[tx][ty];
    endfunction

    // One tick of the game: requested direction, else keep going, else stand still.
    task automatic model_step();
        int tx, ty, nx, ny; bit blk, go;
        go = 0;
        tgt(m_x, m_y, m_pend, tx, ty, blk);
        if (!blk) begin go = 1; m_cur = m_pend; nx = tx; ny = ty; end
        else begin
            tgt(m_x, m_y, m_cur, tx, ty, blk);
            if (!blk) begin go = 1; nx = tx; ny = ty; end
        end
        if (go) begin
            exp_plot.push_back('{m_x, m_y, 1});
            exp_plot.push_back('{nx, ny, 0});
            exp_mv.push_back('{nx, ny, m_cur});
            m_x = nx; m_y = ny;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock_50); #1; end
    endtask

    task automatic set_dir(input int d);
        dir_req = 2'(d); dir_req_valid = 1; cyc(1); dir_req_valid = 0; m_pend = d;
    endtask

    task automatic tick(input bit use_model);
        reduced_clock = ~reduced_clock;
        if (en && use_model) model_step();
    endtask

    task automatic clear_walls();
        for (int x = 0; x <= MAX_X; x++) for (int y = 0; y <= MAX_Y; y++) wall_mem[x][y] = 0;
    endtask

    task automatic do_reset();
        reset = 1; reduced_clock = 0; dir_req_valid = 0; cyc(2);
        chk("rst_pos_x", pos_x, 80);       chk("rst_pos_y", pos_y, 60);
        chk("rst_cur_dir", cur_dir, 2);     chk("rst_plot_req", plot_req, 0);
        chk("rst_moved", moved, 0);         chk("rst_overrun", tick_overrun, 0);
        chk("rst_probe_x", probe_x, 80);    chk("rst_probe_y", probe_y, 60);
        chk("rst_plot_erase", plot_erase, 0);
        exp_plot.delete(); exp_mv.delete(); probe_log.delete();
        m_x = 80; m_y = 60; m_cur = 2; m_pend = 2; cur_x = 80; cur_y = 60;
        moves_seen = 0; req_cycles = 0; seen_overrun = 0; last_probe = 80 * 256 + 60;
        reset = 0; cyc(1);
    endtask

    initial begin clock_50 = 0; forever #5 clock_50 = ~clock_50; end

    // Maze ROM: answers for the probe of the previous cycle.
    initial begin
        int lx, ly;
        probe_wall = 0;
        forever begin
            @(negedge clock_50); lx = probe_x; ly = probe_y;
            @(posedge clock_50); #1;
            probe_wall = (lx <= MAX_X && ly <= MAX_Y) ? wall_mem[lx][ly] : 1'b1;
        end
    end

    // Plotter: acks each request after 0..ack_max cycles, one-cycle pulse.
    initial begin
        int cnt;
        cnt = -1; plot_ack = 0;
        forever begin
            @(posedge clock_50); #1;
            if (reset) begin plot_ack = 0; cnt = -1; end
            else if (plot_ack) plot_ack = 0;
            else if (plot_req && !ack_hold) begin
                if (cnt < 0) cnt = $urandom_range(0, ack_max);
                if (cnt == 0) begin plot_ack = 1; cnt = -1; end
                else cnt--;
            end
        end
    end

    // Compare process: every cycle out of reset.
    initial begin
        bit pr; bit pa; int px, py, pe;
        plot_t ep; mv_t em;
        pr = 0; pa = 0; px = 0; py = 0; pe = 0;
        forever begin
            @(negedge clock_50);
            if (reset) begin pr = 0; pa = 0; continue; end
            if (moved) begin
                moves_seen++;
                if (exp_mv.size() == 0) chk("moved_unexpected", 1, 0);
                else begin
                    em = exp_mv.pop_front();
                    cur_x = em.x; cur_y = em.y;
                    chk("moved_dir", cur_dir, em.d);
                end
            end
            chk("pos_x", pos_x, cur_x);
            chk("pos_y", pos_y, cur_y);
            if (plot_req) req_cycles++;
            if (plot_req && pr && !pa) begin
                chk("plot_x_stable", plot_x, px);
                chk("plot_y_stable", plot_y, py);
                chk("plot_erase_stable", plot_erase, pe);
            end
            if (plot_req && plot_ack) begin
                if (exp_plot.size() == 0) chk("plot_unexpected", 1, 0);
                else begin
                    ep = exp_plot.pop_front();
                    chk("plot_x", plot_x, ep.x);
                    chk("plot_y", plot_y, ep.y);
                    chk("plot_erase", plot_erase, ep.erase);
                end
            end
            if (tick_overrun) seen_overrun++;
            if (int'(probe_x) * 256 + int'(probe_y) != last_probe) begin
                last_probe = int'(probe_x) * 256 + int'(probe_y);
                probe_log.push_back(last_probe);
            end
            pr = plot_req; pa = plot_ack; px = plot_x; py = plot_y; pe = plot_erase;
        end
    end

    task automatic end_of_test(input string name, input int exp_ovr);
        chk({name, "_plots_left"}, exp_plot.size(), 0);
        chk({name, "_moves_left"}, exp_mv.size(), 0);
        chk({name, "_overrun"}, seen_overrun, exp_ovr);
        chk({name, "_pos_x"}, pos_x, m_x);
        chk({name, "_pos_y"}, pos_y, m_y);
        chk({name, "_cur_dir"}, cur_dir, m_cur);
    endtask

    initial begin
        reset = 1; en = 1; reduced_clock = 0; dir_req = 0; dir_req_valid = 0;
        clear_walls();

        // Open maze, step right.
        do_reset();
        set_dir(3); tick(1);
        chk("t1_model_erase_x", exp_plot[0].x, 80);
        chk("t1_model_draw_x", exp_plot[1].x, 81);
        cyc(30);
        chk("t1_pos_x", pos_x, 81); chk("t1_pos_y", pos_y, 60);
        chk("t1_moves", moves_seen, 1);
        end_of_test("t1", 0);

        // Up is walled, fall back to left.
        do_reset();
        wall_mem[80][59] = 1;
        set_dir(0); tick(1); cyc(30);
        chk("t2_pos_x", pos_x, 79); chk("t2_cur_dir", cur_dir, 2);
        chk("t2_probes", probe_log.size(), 2);
        if (probe_log.size() == 2) begin
            chk("t2_probe0", probe_log[0], 80 * 256 + 59);
            chk("t2_probe1", probe_log[1], 79 * 256 + 60);
        end
        end_of_test("t2", 0);

        // Both blocked: nothing happens; next tick retries once the way opens.
        do_reset();
        wall_mem[80][59] = 1; wall_mem[79][60] = 1;
        set_dir(0); tick(1); cyc(30);
        chk("t3_no_req", req_cycles, 0); chk("t3_no_move", moves_seen, 0);
        chk("t3_pos_x", pos_x, 80);
        wall_mem[79][60] = 0;
        tick(1); cyc(30);
        chk("t3_retry_x", pos_x, 79);
        end_of_test("t3", 0);

        // Horizontal wrap both ways, vertical saturation with fallback.
        clear_walls();
        do_reset();
        set_dir(2);
        repeat (81) begin tick(1); cyc(20); end
        chk("t4_wrap_left_x", pos_x, MAX_X);
        set_dir(3); tick(1); cyc(20);
        chk("t4_wrap_right_x", pos_x, 0);
        set_dir(0);
        repeat (60) begin tick(1); cyc(20); end
        chk("t4_top_y", pos_y, 0);
        set_dir(3); tick(1); cyc(20);
        set_dir(0); tick(1); cyc(20);
        chk("t4_fallback_x", pos_x, 2); chk("t4_fallback_y", pos_y, 0);
        chk("t4_fallback_dir", cur_dir, 3);
        end_of_test("t4", 0);

        // Plotter stalls while two more ticks arrive: one overrun, one extra step.
        do_reset();
        set_dir(3); ack_hold = 1;
        tick(1); cyc(6);
        tick(1); cyc(4);
        tick(0); cyc(10);
        ack_hold = 0; cyc(40);
        chk("t5_pos_x", pos_x, 82);
        chk("t5_moves", moves_seen, 2);
        end_of_test("t5", 1);

        // Reset during erase, then ticks with en low.
        do_reset();
        ack_hold = 1; set_dir(3); tick(0); cyc(5);
        chk("t6_req_in_erase", plot_req, 1);
        reset = 1; reduced_clock = 0; cyc(1);
        chk("t6_rst_req", plot_req, 0); chk("t6_rst_pos_x", pos_x, 80);
        chk("t6_rst_moved", moved, 0);
        ack_hold = 0;
        do_reset();
        en = 0;
        repeat (5) begin tick(1); cyc(15); end
        en = 1; cyc(10);
        chk("t6_en_off_moves", moves_seen, 0);
        end_of_test("t6", 0);

        // Random maze, directions, enables, mid-step requests and ack delays.
        for (int x = 0; x <= MAX_X; x++)
            for (int y = 0; y <= MAX_Y; y++) wall_mem[x][y] = ($urandom_range(0, 3) == 0);
        do_reset();
        ack_max = 3;
        repeat (200) begin
            if ($urandom_range(0, 2) == 0) set_dir($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            tick(1); cyc(3);
            en = 1;
            if ($urandom_range(0, 2) == 0) set_dir($urandom_range(0, 3));
            else cyc(1);
            cyc(26);
        end
        end_of_test("t7", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
